// File: rtl/luma_pkg.sv
`default_nettype none
// ============================================================================
// luma_pkg : shared constants and types for the 16x16 luma intra mode selector
// Revision : 1.0
// ============================================================================
package luma_pkg;

    localparam int PIXW_DEF = 8;
    localparam int BLK_DEF  = 16;

    localparam int SADW_ROW = 12;
    localparam int SADW_MB  = 16;

    localparam logic [1:0] MODE_V  = 2'd0;
    localparam logic [1:0] MODE_H  = 2'd1;
    localparam logic [1:0] MODE_DC = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DECIDE = 2'd2,
        S_OUT    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sad_row16.sv
`default_nettype none
// ============================================================================
// sad_row16 : combinational sum of absolute differences over one 16-pixel row
// Revision  : 1.0
// ============================================================================
module sad_row16
    import luma_pkg::*;
#(
    parameter int PIXW = PIXW_DEF,
    parameter int BLK  = BLK_DEF
) (
    input  logic [BLK*PIXW-1:0] orig_row_i,
    input  logic [BLK*PIXW-1:0] pred_row_i,
    output logic [SADW_ROW-1:0] sad_o
);

    logic [SADW_ROW-1:0] lvl0 [BLK];
    logic [SADW_ROW-1:0] lvl1 [BLK/2];
    logic [SADW_ROW-1:0] lvl2 [BLK/4];
    logic [SADW_ROW-1:0] lvl3 [BLK/8];

    generate
        for (genvar k = 0; k < BLK; k++) begin : g_absdiff
            logic [PIXW-1:0] a;
            logic [PIXW-1:0] b;
            logic [PIXW-1:0] d;
            assign a       = orig_row_i[k*PIXW +: PIXW];
            assign b       = pred_row_i[k*PIXW +: PIXW];
            assign d       = (a > b) ? (a - b) : (b - a);
            assign lvl0[k] = SADW_ROW'(d);
        end
        // Balanced pairwise tree; 12 bits holds 16 * 255 at every level.
        for (genvar i = 0; i < BLK/2; i++) begin : g_lvl1
            assign lvl1[i] = lvl0[2*i] + lvl0[2*i+1];
        end
        for (genvar i = 0; i < BLK/4; i++) begin : g_lvl2
            assign lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
        end
        for (genvar i = 0; i < BLK/8; i++) begin : g_lvl3
            assign lvl3[i] = lvl2[2*i] + lvl2[2*i+1];
        end
    endgenerate

    assign sad_o = lvl3[0] + lvl3[1];

endmodule
`default_nettype wire

// File: rtl/luma16x16_modesel.sv
`default_nettype none
// ============================================================================
// luma16x16_modesel : accumulates V/H/DC SADs over a 16x16 macroblock, row per
//                     transfer, and reports the cheapest legal intra mode
// Revision          : 1.0
// ============================================================================
module luma16x16_modesel
    import luma_pkg::*;
#(
    parameter int PIXW = PIXW_DEF,
    parameter int BLK  = BLK_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLK*PIXW-1:0] orig_row,
    input  logic [BLK*PIXW-1:0] vpred_row,
    input  logic [BLK*PIXW-1:0] hpred_row,
    input  logic [PIXW-1:0]     dc_val,
    input  logic                avail_top,
    input  logic                avail_left,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          best_mode,
    output logic [SADW_MB-1:0]  best_sad
);

    state_t               state_q, state_d;
    logic [3:0]           row_cnt_q, row_cnt_d;
    logic [SADW_MB-1:0]   acc_v_q, acc_v_d;
    logic [SADW_MB-1:0]   acc_h_q, acc_h_d;
    logic [SADW_MB-1:0]   acc_dc_q, acc_dc_d;
    logic                 avail_top_q, avail_top_d;
    logic                 avail_left_q, avail_left_d;
    logic [1:0]           best_mode_q, best_mode_d;
    logic [SADW_MB-1:0]   best_sad_q, best_sad_d;

    logic [SADW_ROW-1:0]  sad_v, sad_h, sad_dc;
    logic [BLK*PIXW-1:0]  dc_row;
    logic                 xfer;
    logic [1:0]           sel_mode;
    logic [SADW_MB-1:0]   sel_sad;

    assign dc_row = {BLK{dc_val}};

    sad_row16 #(.PIXW(PIXW), .BLK(BLK)) u_sad_v (
        .orig_row_i (orig_row),
        .pred_row_i (vpred_row),
        .sad_o      (sad_v)
    );

    sad_row16 #(.PIXW(PIXW), .BLK(BLK)) u_sad_h (
        .orig_row_i (orig_row),
        .pred_row_i (hpred_row),
        .sad_o      (sad_h)
    );

    sad_row16 #(.PIXW(PIXW), .BLK(BLK)) u_sad_dc (
        .orig_row_i (orig_row),
        .pred_row_i (dc_row),
        .sad_o      (sad_dc)
    );

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
    assign out_valid = (state_q == S_OUT);
    assign xfer      = in_valid && in_ready;
    assign best_mode = best_mode_q;
    assign best_sad  = best_sad_q;

    // Candidates visited from highest to lowest mode with <=, so ties land low.
    always_comb begin
        sel_mode = MODE_DC;
        sel_sad  = acc_dc_q;
        if (avail_left_q && (acc_h_q <= sel_sad)) begin
            sel_mode = MODE_H;
            sel_sad  = acc_h_q;
        end
        if (avail_top_q && (acc_v_q <= sel_sad)) begin
            sel_mode = MODE_V;
            sel_sad  = acc_v_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_cnt_d    = row_cnt_q;
        acc_v_d      = acc_v_q;
        acc_h_d      = acc_h_q;
        acc_dc_d     = acc_dc_q;
        avail_top_d  = avail_top_q;
        avail_left_d = avail_left_q;
        best_mode_d  = best_mode_q;
        best_sad_d   = best_sad_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    acc_v_d      = SADW_MB'(sad_v);
                    acc_h_d      = SADW_MB'(sad_h);
                    acc_dc_d     = SADW_MB'(sad_dc);
                    avail_top_d  = avail_top;
                    avail_left_d = avail_left;
                    row_cnt_d    = 4'd1;
                    state_d      = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (xfer) begin
                    acc_v_d   = acc_v_q + SADW_MB'(sad_v);
                    acc_h_d   = acc_h_q + SADW_MB'(sad_h);
                    acc_dc_d  = acc_dc_q + SADW_MB'(sad_dc);
                    row_cnt_d = row_cnt_q + 4'd1;
                    if (row_cnt_q == 4'd15) begin
                        state_d = S_DECIDE;
                    end
                end
            end
            S_DECIDE: begin
                best_mode_d = sel_mode;
                best_sad_d  = sel_sad;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            row_cnt_q    <= '0;
            acc_v_q      <= '0;
            acc_h_q      <= '0;
            acc_dc_q     <= '0;
            avail_top_q  <= 1'b0;
            avail_left_q <= 1'b0;
            best_mode_q  <= '0;
            best_sad_q   <= '0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            acc_v_q      <= acc_v_d;
            acc_h_q      <= acc_h_d;
            acc_dc_q     <= acc_dc_d;
            avail_top_q  <= avail_top_d;
            avail_left_q <= avail_left_d;
            best_mode_q  <= best_mode_d;
            best_sad_q   <= best_sad_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_luma16x16_modesel.sv
`default_nettype none
// ============================================================================
// tb_luma16x16_modesel : directed and randomized macroblocks against a
//                        pixel-level SAD reference model
// Revision             : 1.0
// ============================================================================
module tb_luma16x16_modesel;

    localparam int PIXW = 8;
    localparam int BLK  = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   orig_row;
    logic [127:0]   vpred_row;
    logic [127:0]   hpred_row;
    logic [7:0]     dc_val;
    logic           avail_top;
    logic           avail_left;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     best_mode;
    logic [15:0]    best_sad;

    luma16x16_modesel #(.PIXW(PIXW), .BLK(BLK)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .orig_row   (orig_row),
        .vpred_row  (vpred_row),
        .hpred_row  (hpred_row),
        .dc_val     (dc_val),
        .avail_top  (avail_top),
        .avail_left (avail_left),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .best_mode  (best_mode),
        .best_sad   (best_sad)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] o_rows [16];
    logic [127:0] v_rows [16];
    logic [127:0] h_rows [16];
    logic [7:0]   mb_dc;
    bit           mb_top;
    bit           mb_left;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pix_sad(input logic [127:0] a, input logic [127:0] b);
        int s;
        int x;
        int y;
        s = 0;
        for (int k = 0; k < 16; k++) begin
            x = int'(a[8*k +: 8]);
            y = int'(b[8*k +: 8]);
            s += (x > y) ? (x - y) : (y - x);
        end
        return s;
    endfunction

    // Whole-macroblock costs, then the cheapest legal mode scanning 0..2 with strict <.
    task automatic model(output int m, output int s);
        int  cost [3];
        bit  legal [3];
        logic [127:0] dcr;
        dcr = {16{mb_dc}};
        cost[0] = 0; cost[1] = 0; cost[2] = 0;
        for (int r = 0; r < 16; r++) begin
            cost[0] += pix_sad(o_rows[r], v_rows[r]);
            cost[1] += pix_sad(o_rows[r], h_rows[r]);
            cost[2] += pix_sad(o_rows[r], dcr);
        end
        legal[0] = mb_top;
        legal[1] = mb_left;
        legal[2] = 1'b1;
        m = -1;
        s = 0;
        for (int mm = 0; mm < 3; mm++) begin
            if (legal[mm] && (m < 0 || cost[mm] < s)) begin
                m = mm;
                s = cost[mm];
            end
        end
    endtask

    task automatic fill_const(input logic [7:0] ov, input logic [7:0] vv,
                              input logic [7:0] hv, input logic [7:0] dv);
        for (int r = 0; r < 16; r++) begin
            o_rows[r] = {16{ov}};
            v_rows[r] = {16{vv}};
            h_rows[r] = {16{hv}};
        end
        mb_dc = dv;
    endtask

    task automatic fill_random();
        for (int r = 0; r < 16; r++) begin
            o_rows[r] = {$urandom, $urandom, $urandom, $urandom};
            v_rows[r] = o_rows[r] ^ {4{$urandom & 32'h0f0f0f0f}};
            h_rows[r] = o_rows[r] ^ {4{$urandom & 32'h0f0f0f0f}};
        end
        mb_dc   = 8'($urandom);
        mb_top  = 1'($urandom);
        mb_left = 1'($urandom);
    endtask

    task automatic present_row(input int r);
        orig_row  = o_rows[r];
        vpred_row = v_rows[r];
        hpred_row = h_rows[r];
        dc_val    = mb_dc;
        in_valid  = 1'b1;
    endtask

    task automatic idle_gap();
        in_valid  = 1'b0;
        orig_row  = {$urandom, $urandom, $urandom, $urandom};
        vpred_row = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
    endtask

    task automatic run_mb(input bit gaps, input bit scramble, input int bp);
        int em;
        int es;
        int t_last;
        int lat;
        model(em, es);
        t_last = 0;
        out_ready = 1'b0;
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            if (gaps && r > 0) begin
                repeat ($urandom_range(0, 2)) idle_gap();
            end
            present_row(r);
            if (r == 0) begin
                avail_top  = mb_top;
                avail_left = mb_left;
            end else if (scramble) begin
                avail_top  = 1'($urandom);
                avail_left = 1'($urandom);
            end
            chk("row_in_ready", 32'(in_ready), 32'd1);
            if (r == 15) t_last = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("decide_out_valid", 32'(out_valid), 32'd0);
        chk("decide_in_ready", 32'(in_ready), 32'd0);
        lat = -1;
        for (int w = 0; w < 8 && lat < 0; w++) begin
            @(negedge clk);
            if (out_valid === 1'b1) lat = cyc - t_last;
        end
        chk("latency", 32'(lat), 32'd2);
        chk("best_mode", 32'(best_mode), 32'(em));
        chk("best_sad", 32'(best_sad), 32'(es));
        chk("out_in_ready", 32'(in_ready), 32'd0);
        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_mode", 32'(best_mode), 32'(em));
            chk("hold_sad", 32'(best_sad), 32'(es));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        orig_row   = '0;
        vpred_row  = '0;
        hpred_row  = '0;
        dc_val     = '0;
        avail_top  = 1'b0;
        avail_left = 1'b0;
        out_ready  = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_best_mode", 32'(best_mode), 32'd0);
        chk("rst_best_sad", 32'(best_sad), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Vertical wins outright.
        fill_const(8'd100, 8'd100, 8'd50, 8'd75);
        mb_top = 1'b1; mb_left = 1'b1;
        run_mb(1'b0, 1'b0, 0);

        // Horizontal matches exactly; vertical sits 10 off on every pixel.
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < 16; k++) begin
                o_rows[r][8*k +: 8] = 8'(r * 9 + k * 5);
                v_rows[r][8*k +: 8] = 8'(r * 9 + k * 5 + 10);
            end
            h_rows[r] = o_rows[r];
        end
        mb_dc = 8'd128; mb_top = 1'b1; mb_left = 1'b1;
        run_mb(1'b0, 1'b0, 1);

        // Three-way tie at zero.
        fill_const(8'd80, 8'd80, 8'd80, 8'd80);
        mb_top = 1'b1; mb_left = 1'b1;
        run_mb(1'b0, 1'b0, 0);

        // Vertical illegal; DC beats horizontal. Avail toggles after row 0.
        fill_const(8'd100, 8'd100, 8'd50, 8'd75);
        mb_top = 1'b0; mb_left = 1'b1;
        run_mb(1'b0, 1'b1, 0);

        // Full-scale SAD with backpressure.
        fill_const(8'd255, 8'd0, 8'd0, 8'd0);
        mb_top = 1'b1; mb_left = 1'b1;
        run_mb(1'b0, 1'b0, 5);

        // Abort a macroblock after row 7 with stalls, then run a fresh one.
        fill_random();
        out_ready = 1'b0;
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            if (r > 0) repeat ($urandom_range(0, 2)) idle_gap();
            present_row(r);
            avail_top  = 1'b1;
            avail_left = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("abort_rst_in_ready", 32'(in_ready), 32'd1);
        chk("abort_rst_out_valid", 32'(out_valid), 32'd0);
        chk("abort_rst_best_sad", 32'(best_sad), 32'd0);
        chk("abort_rst_best_mode", 32'(best_mode), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("abort_no_out_valid", 32'(out_valid), 32'd0);
        end
        fill_random();
        run_mb(1'b1, 1'b1, 2);

        for (int n = 0; n < 8; n++) begin
            fill_random();
            run_mb(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/luma16x16_modesel.md
LUMA16X16_MODESEL -- requirements
Module: luma16x16_modesel

Interface
REQ-001 The module SHALL expose parameter PIXW, default 8, the pixel bit width.
REQ-002 The module SHALL expose parameter BLK, default 16, the macroblock edge in pixels, fixed at 16 for this release.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: the row presented on the row inputs is valid.
REQ-006 Port in_ready, output, 1 bit: the block accepts a row this cycle.
REQ-007 Port orig_row, input, BLK*PIXW bits: one row of original luma pixels, with pixel k at bits [8k+7:8k].
REQ-008 Port vpred_row, input, BLK*PIXW bits: the matching row of the vertical prediction.
REQ-009 Port hpred_row, input, BLK*PIXW bits: the matching row of the horizontal prediction.
REQ-010 Port dc_val, input, PIXW bits: the DC prediction value, constant over the macroblock.
REQ-011 Port avail_top, input, 1 bit: top neighbours exist, so vertical mode is legal.
REQ-012 Port avail_left, input, 1 bit: left neighbours exist, so horizontal mode is legal.
REQ-013 Port out_valid, output, 1 bit: the decision is valid.
REQ-014 Port out_ready, input, 1 bit: downstream accepts the decision.
REQ-015 Port best_mode, output, 2 bits: 0 = vertical, 1 = horizontal, 2 = DC.
REQ-016 Port best_sad, output, 16 bits: SAD of the chosen mode.

Function
REQ-017 A row SHALL transfer only on a cycle where in_valid and in_ready are both 1.
REQ-018 The FSM SHALL have exactly four states: IDLE, ACCUM, DECIDE and OUT.
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in DECIDE and OUT.
REQ-020 A transfer in IDLE SHALL load row 0: clear all three accumulators to that row's SADs, latch avail_top and avail_left, set row_cnt=1, and go to ACCUM.
REQ-021 Each transfer in ACCUM SHALL add that row's three SADs to the accumulators and increment row_cnt.
REQ-022 When row_cnt==15 transfers, the FSM SHALL go to DECIDE.
REQ-023 Cycles without a transfer SHALL hold all state.
REQ-024 Row SAD SHALL be the sum over 16 pixels of |orig-pred|: 12-bit unsigned, maximum 4080.
REQ-025 Accumulators SHALL be 16-bit unsigned; the maximum 65280 fits without saturation logic.
REQ-026 DECIDE SHALL select, in one cycle, the minimum SAD among legal modes only.
- DC is always legal.
- Vertical is legal only if latched avail_top=1.
- Horizontal is legal only if latched avail_left=1.
REQ-027 Ties SHALL resolve to the lower mode number.
REQ-028 DECIDE SHALL register best_mode and best_sad, then go to OUT.
REQ-029 out_valid SHALL be 1 exactly in OUT.
REQ-030 Latency SHALL be fixed: last row transfer at cycle n -> out_valid=1 at cycle n+2.
REQ-031 best_mode and best_sad SHALL remain stable while out_valid=1 and out_ready=0.
REQ-032 out_valid & out_ready in OUT SHALL return the FSM to IDLE at the next edge.
- in_ready becomes 1 one cycle after the handshake.
- There is no overlap between macroblocks.
REQ-033 Changes to avail_top and avail_left after row 0 SHALL be ignored until the next macroblock.

Reset
REQ-034 reset=0 SHALL immediately force the FSM to IDLE and clear to 0: row_cnt, accumulators, best_mode, best_sad, out_valid.
REQ-035 in_ready SHALL read 1 during and after reset.
REQ-036 Reset asserted mid-macroblock SHALL discard partial sums.
- No out_valid is produced for the aborted macroblock.
REQ-037 After reset deasserts, the next transfer SHALL be treated as row 0.

Structure
REQ-038 Shared package luma_pkg SHALL hold:
- mode encodings MODE_V=0, MODE_H=1, MODE_DC=2;
- PIXW and BLK defaults;
- SAD width constants (row 12, macroblock 16).
REQ-039 Sub-module sad_row16 SHALL compute one 16-pixel row SAD as a combinational adder tree, instantiated three times (V, H, DC).
REQ-040 The DC instance SHALL receive dc_val replicated across all 16 pixels.

Verification
REQ-041 Vertical case: orig all 100, vpred 100, hpred 50, dc 75, both avail=1 -> best_mode=0, best_sad=0.
REQ-042 Horizontal case: orig row i equal to hpred row i, vpred offset by 10 per pixel -> best_mode=1, best_sad=0.
REQ-043 Tie case: all inputs 80 -> best_mode=0, best_sad=0.
REQ-044 Availability case: REQ-041 stimulus with avail_top=0 -> best_mode=2, best_sad=6400 (H=12800).
REQ-045 Overflow and backpressure case: orig 255, all preds 0, out_ready held 0 for 5 cycles.
- best_sad=65280 throughout, values stable.
- Returns to IDLE after the out_ready pulse.
REQ-046 Reset and stall case: reset pulsed after row 7, with in_valid gaps inside ACCUM.
- No out_valid for the aborted macroblock.
- The following macroblock yields the correct result at exactly n+2.
